// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU: widths, opcodes, bubble encoding, fetch FSM states.
// Pure declarations: no latency and no backpressure apply.
package cpu_pkg;

  localparam int ISIZE = 16;
  localparam int RSIZE = 3;  // register-index width (8 GPRs)

  localparam logic [3:0] OP_B    = 4'hC;
  localparam logic [3:0] OP_JAL  = 4'hD;
  localparam logic [3:0] OP_JR   = 4'hE;
  localparam logic [3:0] OP_EXEC = 4'hF;

  localparam logic [ISIZE-1:0] NOP_INSTR = 16'h0000;  // ADD R0,R0,R0

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_EXEC = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_perf_counter.sv
// Saturating event counter; one cycle from enable to count update.
// No backpressure: the count sticks at all-ones instead of wrapping.
module fetch_perf_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register with redirect and EXEC detours; word at PC lands in IF/ID one edge later.
// stall freezes every register; optional counters enabled by FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter int               ISIZE = 16,
  parameter int               ASIZE = 8,
  parameter logic [ISIZE-1:0] NOP   = 16'h0000
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [ASIZE-1:0] imem_addr,
  input  logic [ISIZE-1:0] imem_data,
  input  logic             stall,
  input  logic             redirect,
  input  logic [ASIZE-1:0] redirect_pc,
  input  logic             exec_req,
  input  logic [ASIZE-1:0] exec_pc,
  output logic [ISIZE-1:0] if_instr,
  output logic [ASIZE-1:0] if_pc,
  output logic             if_valid,
  output logic [ISIZE-1:0] last_instr,
  output logic [3:0]       exec_test,
  output logic             last_pcctrl
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]      perf_fetched,
  output logic [15:0]      perf_bubbles
`endif
);

  import cpu_pkg::*;

  fetch_state_t     state, state_n;
  logic [ASIZE-1:0] pc, pc_n, ret_pc, ret_pc_n, if_pc_n;
  logic [ISIZE-1:0] if_instr_n, last_instr_n;
  logic             if_valid_n, last_pcctrl_n;
  logic             primed, primed_n;
  logic             nested;

  assign imem_addr = pc;
  assign exec_test = last_instr[ISIZE-1 -: 4];
  assign nested    = (imem_data[ISIZE-1 -: 4] == OP_EXEC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      pc          <= '0;
      ret_pc      <= '0;
      if_instr    <= NOP;
      if_pc       <= '0;
      if_valid    <= 1'b0;
      last_instr  <= NOP;
      last_pcctrl <= 1'b0;
      primed      <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      ret_pc      <= ret_pc_n;
      if_instr    <= if_instr_n;
      if_pc       <= if_pc_n;
      if_valid    <= if_valid_n;
      last_instr  <= last_instr_n;
      last_pcctrl <= last_pcctrl_n;
      primed      <= primed_n;
    end
  end

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    ret_pc_n      = ret_pc;
    if_instr_n    = if_instr;
    if_pc_n       = if_pc;
    if_valid_n    = if_valid;
    last_instr_n  = last_instr;
    last_pcctrl_n = last_pcctrl;
    primed_n      = primed;
    if (!stall) begin
      primed_n      = 1'b1;
      last_pcctrl_n = redirect;
      last_instr_n  = if_instr;
      if_pc_n       = pc;
      if (redirect) begin
        // Redirect also cancels a pending EXEC return.
        pc_n       = redirect_pc;
        if_instr_n = NOP;
        if_valid_n = 1'b0;
        state_n    = ST_RUN;
      end else if ((state == ST_RUN) && exec_req) begin
        ret_pc_n   = pc;
        pc_n       = exec_pc;
        if_instr_n = NOP;
        if_valid_n = 1'b0;
        state_n    = ST_EXEC;
      end else if (state == ST_EXEC) begin
        // A nested EXEC target is squashed rather than followed.
        if_instr_n = nested ? NOP : imem_data;
        if_valid_n = !nested;
        pc_n       = ret_pc;
        state_n    = ST_RUN;
      end else begin
        // The first edge out of reset is not counted as a real fetch.
        if_instr_n = imem_data;
        if_valid_n = primed;
        pc_n       = pc + ASIZE'(1);
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic load_valid, load_bubble;

  assign load_valid  = !stall && if_valid_n;
  assign load_bubble = !stall && !if_valid_n && primed;

  fetch_perf_counter #(.W(16)) u_perf_fetched (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (load_valid),
    .count (perf_fetched)
  );

  fetch_perf_counter #(.W(16)) u_perf_bubbles (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (load_bubble),
    .count (perf_bubbles)
  );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected IF/ID contents queued as stimulus is driven, popped after each edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic        stall, redirect, exec_req;
  logic [7:0]  redirect_pc, exec_pc;
  logic [15:0] if_instr, last_instr;
  logic [7:0]  if_pc;
  logic        if_valid, last_pcctrl;
  logic [3:0]  exec_test;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_fetched, perf_bubbles;
`endif

  logic [15:0] mem [256];
  assign imem_data = mem[imem_addr];

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .exec_req    (exec_req),
    .exec_pc     (exec_pc),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_valid    (if_valid),
    .last_instr  (last_instr),
    .exec_test   (exec_test),
    .last_pcctrl (last_pcctrl)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_bubbles(perf_bubbles)
`endif
  );

  typedef struct packed {
    logic [15:0] instr;
    logic [7:0]  pc;
    logic        valid;
    logic        chk_pc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Queue the expected IF/ID contents, advance one edge, then compare against the popped entry.
  task automatic step(input string tag, input logic [15:0] ei, input logic [7:0] ep,
                      input logic ev, input logic cp);
    exp_t e;
    sb.push_back('{instr: ei, pc: ep, valid: ev, chk_pc: cp});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, ".instr"}, if_instr, e.instr);
    check({tag, ".valid"}, {15'd0, if_valid}, {15'd0, e.valid});
    if (e.chk_pc) check({tag, ".pc"}, {8'd0, if_pc}, {8'd0, e.pc});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".imem_addr"}, {8'd0, imem_addr}, 16'h0000);
    check({tag, ".if_instr"}, if_instr, 16'h0000);
    check({tag, ".if_pc"}, {8'd0, if_pc}, 16'h0000);
    check({tag, ".if_valid"}, {15'd0, if_valid}, 16'h0000);
    check({tag, ".last_instr"}, last_instr, 16'h0000);
    check({tag, ".exec_test"}, {12'd0, exec_test}, 16'h0000);
    check({tag, ".last_pcctrl"}, {15'd0, last_pcctrl}, 16'h0000);
`ifdef FETCH_PERF_CNT_EN
    check({tag, ".perf_fetched"}, perf_fetched, 16'h0000);
    check({tag, ".perf_bubbles"}, perf_bubbles, 16'h0000);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i);
    mem[8'h11] = 16'hA011;
    mem[8'h90] = 16'hF123;
    rst_n = 1'b0;
    stall = 1'b0; redirect = 1'b0; exec_req = 1'b0;
    redirect_pc = 8'h00; exec_pc = 8'h00;
    #2;
    check_reset_values("reset");
    #10 rst_n = 1'b1;

    // Sequential fetch; first edge out of reset is a non-valid load.
    step("seq0", 16'h0000, 8'h00, 1'b0, 1'b1);
    step("seq1", 16'h0001, 8'h01, 1'b1, 1'b1);
    step("seq2", 16'h0002, 8'h02, 1'b1, 1'b1);
    check("seq2.last_instr", last_instr, 16'h0001);
    step("seq3", 16'h0003, 8'h03, 1'b1, 1'b1);
    step("seq4", 16'h0004, 8'h04, 1'b1, 1'b1);
    check("seq4.imem_addr", {8'd0, imem_addr}, 16'h0005);

    // Redirect from PC=05 to 40.
    redirect = 1'b1; redirect_pc = 8'h40;
    step("redir_bubble", 16'h0000, 8'h00, 1'b0, 1'b0);
    check("redir.last_pcctrl", {15'd0, last_pcctrl}, 16'h0001);
    check("redir.imem_addr", {8'd0, imem_addr}, 16'h0040);
    redirect = 1'b0;
    step("redir_target", 16'h0040, 8'h40, 1'b1, 1'b1);
    check("redir_target.last_pcctrl", {15'd0, last_pcctrl}, 16'h0000);

    // Get PC to 10, then EXEC to 80; exec_req held high through EXEC must be ignored.
    redirect = 1'b1; redirect_pc = 8'h10;
    step("to10_bubble", 16'h0000, 8'h00, 1'b0, 1'b0);
    redirect = 1'b0; exec_req = 1'b1; exec_pc = 8'h80;
    step("exec_bubble", 16'h0000, 8'h00, 1'b0, 1'b0);
    check("exec.imem_addr", {8'd0, imem_addr}, 16'h0080);
    step("exec_target", 16'h0080, 8'h80, 1'b1, 1'b1);
    exec_req = 1'b0;
    step("exec_return", 16'h0010, 8'h10, 1'b1, 1'b1);

    // Nested EXEC target (opcode F) is squashed, then fetch resumes at the return PC.
    exec_req = 1'b1; exec_pc = 8'h90;
    step("nest_bubble", 16'h0000, 8'h00, 1'b0, 1'b0);
    exec_req = 1'b0;
    step("nest_squash", 16'h0000, 8'h00, 1'b0, 1'b0);
    check("nest.imem_addr", {8'd0, imem_addr}, 16'h0011);
    step("nest_return", 16'hA011, 8'h11, 1'b1, 1'b1);
    step("after_nest", 16'h0012, 8'h12, 1'b1, 1'b1);
    check("after_nest.exec_test", {12'd0, exec_test}, 16'h000A);
    check("after_nest.last_instr", last_instr, 16'hA011);

    // Stall with redirect held: everything frozen for three edges.
    stall = 1'b1; redirect = 1'b1; redirect_pc = 8'h30;
    for (int k = 0; k < 3; k++) begin
      step("stall", 16'h0012, 8'h12, 1'b1, 1'b1);
      check("stall.imem_addr", {8'd0, imem_addr}, 16'h0013);
      check("stall.last_pcctrl", {15'd0, last_pcctrl}, 16'h0000);
      check("stall.last_instr", last_instr, 16'hA011);
    end
    stall = 1'b0;
    step("unstall_redir", 16'h0000, 8'h00, 1'b0, 1'b0);
    check("unstall.imem_addr", {8'd0, imem_addr}, 16'h0030);
    check("unstall.last_pcctrl", {15'd0, last_pcctrl}, 16'h0001);

    // Redirect and exec_req together: redirect wins, no EXEC detour follows.
    redirect = 1'b1; redirect_pc = 8'h50; exec_req = 1'b1; exec_pc = 8'h80;
    step("both_bubble", 16'h0000, 8'h00, 1'b0, 1'b0);
    check("both.imem_addr", {8'd0, imem_addr}, 16'h0050);
    redirect = 1'b0; exec_req = 1'b0;
    step("both_target", 16'h0050, 8'h50, 1'b1, 1'b1);
    step("both_next", 16'h0051, 8'h51, 1'b1, 1'b1);

    // PC wrap 255 -> 0.
    redirect = 1'b1; redirect_pc = 8'hFE;
    step("wrap_bubble", 16'h0000, 8'h00, 1'b0, 1'b0);
    redirect = 1'b0;
    step("wrap_fe", 16'h00FE, 8'hFE, 1'b1, 1'b1);
    step("wrap_ff", 16'h00FF, 8'hFF, 1'b1, 1'b1);
    check("wrap.imem_addr", {8'd0, imem_addr}, 16'h0000);
    step("wrap_00", 16'h0000, 8'h00, 1'b1, 1'b1);

    // Asynchronous reset in the middle of an EXEC detour.
    exec_req = 1'b1; exec_pc = 8'h80;
    step("rst_exec_bubble", 16'h0000, 8'h00, 1'b0, 1'b0);
    exec_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("midexec_reset");
    #2 rst_n = 1'b1;
    step("post_rst0", 16'h0000, 8'h00, 1'b0, 1'b1);
    check("post_rst0.imem_addr", {8'd0, imem_addr}, 16'h0001);
    step("post_rst1", 16'h0001, 8'h01, 1'b1, 1'b1);
`ifdef FETCH_PERF_CNT_EN
    check("post_rst.perf_fetched", perf_fetched, 16'h0001);
    check("post_rst.perf_bubbles", perf_bubbles, 16'h0000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
